// File: rtl/quick_spi_pkg.sv
// rtl/quick_spi_pkg.sv - shared state encoding, opcode constants and counter sizing for quick_spi
//
// Purpose: types and constants shared by the quick_spi responder and its
//          synchroniser helper.
// Contents: state_t (IDLE/RX_CMD/DELAY/TX_DATA/DONE), READ/WRITE opcode
//           values carried in the command MSB, cnt_bits() counter sizing.
package quick_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_CMD,
    DELAY,
    TX_DATA,
    DONE
  } state_t;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/quick_spi_sync_edge.sv
// rtl/quick_spi_sync_edge.sv - synchroniser and edge strobes for sclk/ss_n/mosi
//
// Purpose: brings the asynchronous SPI pins into the clk domain and derives
//          single-cycle edge strobes from the last two synchronised samples.
// Parameter: SYNC_STAGES - synchroniser depth (>= 2).
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   sclk, ss_n, mosi      raw SPI pins
//   sclk_rise, sclk_fall  1-cycle strobes on synchronised sclk edges
//   ss_fall, ss_rise      1-cycle strobes on synchronised ss_n edges
//   mosi_s                synchronised mosi, aligned with the sclk strobes
module quick_spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  // One extra history flop beyond the synchroniser for edge detection.
  logic [SYNC_STAGES:0]   sclk_q;
  logic [SYNC_STAGES:0]   ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  // ss_n history resets low: a frame already in progress when reset
  // releases shows up as "still selected", so no falling edge is seen until
  // the master deselects and selects again.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_q <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      ss_q   <= {ss_q[SYNC_STAGES-1:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign ss_rise   = ss_q[SYNC_STAGES-1] & ~ss_q[SYNC_STAGES];
  assign ss_fall   = ~ss_q[SYNC_STAGES-1] & ss_q[SYNC_STAGES];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/quick_spi_slave.sv
// rtl/quick_spi_slave.sv - oversampling SPI responder: command receive, delayed read response
//
// Purpose: receives an RX_WIDTH-bit command MSB first; when the command MSB
//          is READ, drives a TX_WIDTH-bit response after TX_DELAY_BITS dummy
//          SCLK periods.
// Option:  QUICK_SPI_SLAVE_TRISTATE_EN - miso floats (1'bz) while miso_oe=0.
// Ports:
//   clk, reset_n   system clock (>= 8x SCLK), synchronous active-low reset
//   sclk, ss_n     SPI clock and select from the master (asynchronous)
//   mosi, miso     serial data in / out; miso_oe high while miso is owned
//   rx_data        last complete command word
//   rx_valid       1-cycle pulse when rx_data updates
//   rd_req         1-cycle pulse with rx_valid when the command is a read
//   tx_data        response word, taken at load if tx_valid is high
//   tx_valid       response present; low at load -> zeros are sent
//   tx_underrun    1-cycle pulse, response loaded without tx_valid
//   frame_error    1-cycle pulse, ss_n released part way into a command
//   busy           frame in progress
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int RX_WIDTH      = 16,
  parameter int TX_WIDTH      = 8,
  parameter int CPOL          = 0,
  parameter int CPHA          = 0,
  parameter int TX_DELAY_BITS = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                ss_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  output logic                rd_req,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_underrun,
  output logic                frame_error,
  output logic                busy
);

  localparam int BW = cnt_bits(RX_WIDTH);
  localparam int DW = cnt_bits(TX_DELAY_BITS);
  localparam int TW = cnt_bits(TX_WIDTH);

  logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;

  quick_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .mosi_s    (mosi_s)
  );

  // Leading edge moves sclk away from its idle level.
  logic leading, trailing, sample_edge, shift_edge;
  assign leading     = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trailing    = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? leading : trailing;
  assign shift_edge  = (CPHA == 0) ? trailing : leading;

  state_t              state, state_d;
  logic [BW-1:0]       bit_cnt, bit_cnt_d;
  logic [DW-1:0]       dly_cnt, dly_cnt_d;
  logic [TW-1:0]       tx_cnt, tx_cnt_d;
  logic [RX_WIDTH-1:0] rx_shift, rx_shift_d, rx_next, rx_data_d;
  logic [TX_WIDTH-1:0] tx_shift, tx_shift_d, tx_word;
  logic                miso_r, miso_d, miso_oe_d;
  logic                rx_valid_d, rd_req_d, tx_underrun_d, frame_error_d;
  logic                load_go;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      dly_cnt     <= '0;
      tx_cnt      <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      miso_r      <= 1'b0;
      miso_oe     <= 1'b0;
      rx_valid    <= 1'b0;
      rd_req      <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      dly_cnt     <= dly_cnt_d;
      tx_cnt      <= tx_cnt_d;
      rx_shift    <= rx_shift_d;
      tx_shift    <= tx_shift_d;
      rx_data     <= rx_data_d;
      miso_r      <= miso_d;
      miso_oe     <= miso_oe_d;
      rx_valid    <= rx_valid_d;
      rd_req      <= rd_req_d;
      tx_underrun <= tx_underrun_d;
      frame_error <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    dly_cnt_d     = dly_cnt;
    tx_cnt_d      = tx_cnt;
    rx_shift_d    = rx_shift;
    tx_shift_d    = tx_shift;
    rx_data_d     = rx_data;
    miso_d        = miso_r;
    miso_oe_d     = miso_oe;
    rx_valid_d    = 1'b0;
    rd_req_d      = 1'b0;
    tx_underrun_d = 1'b0;
    frame_error_d = 1'b0;
    rx_next       = {rx_shift[RX_WIDTH-2:0], mosi_s};
    tx_word       = tx_valid ? tx_data : '0;
    // With CPHA=0 the first response bit must be on the wire before the
    // next leading edge, so it loads on the last dummy sample edge. With
    // CPHA=1 it waits for the following leading (shift) edge so miso only
    // ever changes on leading edges.
    if (CPHA == 0) load_go = sample_edge && (dly_cnt == DW'(TX_DELAY_BITS - 1));
    else           load_go = shift_edge && (dly_cnt == DW'(TX_DELAY_BITS));

    // Deselect has priority over any edge seen in the same cycle.
    if (ss_rise) begin
      frame_error_d = (state == RX_CMD) && (bit_cnt != '0);
      state_d       = IDLE;
      bit_cnt_d     = '0;
      dly_cnt_d     = '0;
      tx_cnt_d      = '0;
      tx_shift_d    = '0;
      miso_d        = 1'b0;
      miso_oe_d     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state_d    = RX_CMD;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
          end
        end
        RX_CMD: begin
          if (sample_edge) begin
            rx_shift_d = rx_next;
            bit_cnt_d  = bit_cnt + 1'b1;
            if (bit_cnt == BW'(RX_WIDTH - 1)) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              case (rx_next[RX_WIDTH-1])
                READ: begin
                  rd_req_d  = 1'b1;
                  dly_cnt_d = '0;
                  state_d   = DELAY;
                end
                WRITE: state_d = DONE;
              endcase
            end
          end
        end
        DELAY: begin
          if (sample_edge && (dly_cnt != DW'(TX_DELAY_BITS))) dly_cnt_d = dly_cnt + 1'b1;
          if (load_go) begin
            tx_shift_d    = tx_word;
            miso_d        = tx_word[TX_WIDTH-1];
            miso_oe_d     = 1'b1;
            tx_underrun_d = !tx_valid;
            tx_cnt_d      = '0;
            state_d       = TX_DATA;
          end
        end
        TX_DATA: begin
          if (sample_edge) begin
            tx_cnt_d = tx_cnt + 1'b1;
            if (tx_cnt == TW'(TX_WIDTH - 1)) begin
              state_d   = DONE;
              miso_d    = 1'b0;
              miso_oe_d = 1'b0;
            end
          end else if (shift_edge && (tx_cnt != '0)) begin
            // No shift before the first bit has been sampled by the master.
            tx_shift_d = {tx_shift[TX_WIDTH-2:0], 1'b0};
            miso_d     = tx_shift[TX_WIDTH-2];
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef QUICK_SPI_SLAVE_TRISTATE_EN
  assign miso = miso_oe ? miso_r : 1'bz;
`else
  assign miso = miso_r;
`endif

endmodule

// File: tb/tb_quick_spi_slave.sv
// tb/tb_quick_spi_slave.sv - directed self-checking bench for quick_spi_slave (mode 0 and mode 3)
module tb_quick_spi_slave;
  localparam int H = 6;  // clk cycles per SCLK half period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, sclk, mosi, ss0_n, ss3_n;
  logic [7:0]  tx_data, cfg_data;
  logic        tx_valid, cfg_valid;
  logic        miso0, miso_oe0, rx_valid0, rd_req0, und0, fe0, busy0;
  logic        miso3, miso_oe3, rx_valid3, rd_req3, und3, fe3, busy3;
  logic [15:0] rx_data0, rx_data3;
  logic [7:0]  resp;

  quick_spi_slave #(.RX_WIDTH(16), .TX_WIDTH(8), .CPOL(0), .CPHA(0),
                    .TX_DELAY_BITS(3), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss0_n), .mosi(mosi),
    .miso(miso0), .miso_oe(miso_oe0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rd_req(rd_req0), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_underrun(und0), .frame_error(fe0), .busy(busy0));

  quick_spi_slave #(.RX_WIDTH(16), .TX_WIDTH(8), .CPOL(1), .CPHA(1),
                    .TX_DELAY_BITS(3), .SYNC_STAGES(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss3_n), .mosi(mosi),
    .miso(miso3), .miso_oe(miso_oe3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .rd_req(rd_req3), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_underrun(und3), .frame_error(fe3), .busy(busy3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_cmd_cyc = 0;

  int rxv_cnt[2] = '{0, 0};
  int rd_cnt[2]  = '{0, 0};
  int rdv_cnt[2] = '{0, 0};
  int und_cnt[2] = '{0, 0};
  int fe_cnt[2]  = '{0, 0};
  int oe_cnt[2]  = '{0, 0};
  int rxv_cyc[2] = '{0, 0};
  logic [15:0] rx_last[2] = '{16'h0, 16'h0};
  int s_rxv[2], s_rd[2], s_rdv[2], s_und[2], s_fe[2], s_oe[2];

  always @(negedge clk) begin
    if (rx_valid0) begin
      rxv_cnt[0] <= rxv_cnt[0] + 1; rx_last[0] <= rx_data0; rxv_cyc[0] <= cyc;
    end
    if (rd_req0)              rd_cnt[0]  <= rd_cnt[0] + 1;
    if (rd_req0 && rx_valid0) rdv_cnt[0] <= rdv_cnt[0] + 1;
    if (und0)                 und_cnt[0] <= und_cnt[0] + 1;
    if (fe0)                  fe_cnt[0]  <= fe_cnt[0] + 1;
    if (miso_oe0)             oe_cnt[0]  <= oe_cnt[0] + 1;
    if (rx_valid3) begin
      rxv_cnt[1] <= rxv_cnt[1] + 1; rx_last[1] <= rx_data3; rxv_cyc[1] <= cyc;
    end
    if (rd_req3)              rd_cnt[1]  <= rd_cnt[1] + 1;
    if (rd_req3 && rx_valid3) rdv_cnt[1] <= rdv_cnt[1] + 1;
    if (und3)                 und_cnt[1] <= und_cnt[1] + 1;
    if (fe3)                  fe_cnt[1]  <= fe_cnt[1] + 1;
    if (miso_oe3)             oe_cnt[1]  <= oe_cnt[1] + 1;
  end

  // Application side: present the response a few clk after each read request.
  initial begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_req0 || rd_req3) begin
        repeat (4) @(negedge clk);
        tx_data  = cfg_data;
        tx_valid = cfg_valid;
        repeat (60) @(negedge clk);
        tx_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rxv = rxv_cnt; s_rd = rd_cnt; s_rdv = rdv_cnt;
    s_und = und_cnt; s_fe = fe_cnt; s_oe = oe_cnt;
  endtask

  function automatic logic miso_of(input int d);
    return (d == 0) ? miso0 : miso3;
  endfunction

  // d=0 drives the mode-0 DUT, d=1 the mode-3 DUT. nclk SCLK periods are
  // issued; a read frame needs 16 + 3 + 8 = 27, response bits are 19..26.
  task automatic spi_frame(input int d, input logic [15:0] cmd, input int nclk,
                           input bit release_ss, output logic [7:0] rsp);
    logic       cpol, cpha, prev;
    logic [15:0] sh;
    cpol = (d == 1);
    cpha = (d == 1);
    sh   = cmd;
    rsp  = 8'h00;
    prev = 1'b0;
    sclk = cpol;
    repeat (4) @(negedge clk);
    if (d == 0) ss0_n = 1'b0; else ss3_n = 1'b0;
    mosi = sh[15];
    repeat (H) @(negedge clk);
    chk("busy_in_frame", 32'(d == 0 ? busy0 : busy3), 32'd1);
    for (int i = 0; i < nclk; i++) begin
      if (cpha && i >= 20 && i < 27) chk("mode3_miso_stable", 32'(miso3), 32'(prev));
      if (!cpha && i >= 19 && i < 27) rsp = {rsp[6:0], miso_of(d)};
      if (cpha) mosi = sh[15];
      sclk = ~cpol;
      if (i == 15 && !cpha) last_cmd_cyc = cyc;
      repeat (H) @(negedge clk);
      if (cpha && i >= 19 && i < 27) begin
        prev = miso_of(d);
        rsp  = {rsp[6:0], prev};
      end
      sclk = cpol;
      if (i == 15 && cpha) last_cmd_cyc = cyc;
      sh = sh << 1;
      if (!cpha) mosi = sh[15];
      repeat (H) @(negedge clk);
    end
    if (release_ss) begin
      if (d == 0) ss0_n = 1'b1; else ss3_n = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss0_n = 1'b1; ss3_n = 1'b1;
    cfg_data = 8'h00; cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_mode0", 32'({miso0, miso_oe0, rx_valid0, rd_req0, und0, fe0, busy0, rx_data0}), 32'd0);
    chk("reset_mode3", 32'({miso3, miso_oe3, rx_valid3, rd_req3, und3, fe3, busy3, rx_data3}), 32'd0);

    // Write command, mode 0
    snap();
    spi_frame(0, 16'h8A55, 16, 1'b1, resp);
    repeat (20) @(negedge clk);
    chk("wr_rx_valid_count", 32'(rxv_cnt[0] - s_rxv[0]), 32'd1);
    chk("wr_rx_data", 32'(rx_last[0]), 32'h8A55);
    chk("wr_rd_req_count", 32'(rd_cnt[0] - s_rd[0]), 32'd0);
    chk("wr_miso_oe_cycles", 32'(oe_cnt[0] - s_oe[0]), 32'd0);
    chk("rx_valid_latency", 32'(rxv_cyc[0] - last_cmd_cyc), 32'd3);
    chk("busy_after_frame", 32'(busy0), 32'd0);

    // Read command with response ready, mode 0
    cfg_data = 8'hC3; cfg_valid = 1'b1;
    snap();
    spi_frame(0, 16'h0012, 27, 1'b1, resp);
    repeat (20) @(negedge clk);
    chk("rd_rx_data", 32'(rx_last[0]), 32'h0012);
    chk("rd_req_count", 32'(rd_cnt[0] - s_rd[0]), 32'd1);
    chk("rd_req_with_rx_valid", 32'(rdv_cnt[0] - s_rdv[0]), 32'd1);
    chk("rd_response", 32'(resp), 32'hC3);
    chk("rd_underrun_count", 32'(und_cnt[0] - s_und[0]), 32'd0);

    // Read command with no response available
    cfg_valid = 1'b0;
    snap();
    spi_frame(0, 16'h0012, 27, 1'b1, resp);
    repeat (20) @(negedge clk);
    chk("underrun_response", 32'(resp), 32'h00);
    chk("underrun_count", 32'(und_cnt[0] - s_und[0]), 32'd1);
    chk("underrun_rd_req_count", 32'(rd_cnt[0] - s_rd[0]), 32'd1);

    // Partial command, then a full write
    snap();
    spi_frame(0, 16'hA5A5, 7, 1'b1, resp);
    repeat (20) @(negedge clk);
    chk("partial_frame_error", 32'(fe_cnt[0] - s_fe[0]), 32'd1);
    chk("partial_no_rx_valid", 32'(rxv_cnt[0] - s_rxv[0]), 32'd0);
    snap();
    spi_frame(0, 16'hFFFF, 16, 1'b1, resp);
    repeat (20) @(negedge clk);
    chk("after_partial_rx_data", 32'(rx_last[0]), 32'hFFFF);
    chk("after_partial_rx_valid", 32'(rxv_cnt[0] - s_rxv[0]), 32'd1);
    chk("after_partial_no_error", 32'(fe_cnt[0] - s_fe[0]), 32'd0);

    // Same read in mode 3 (CPOL=1, CPHA=1)
    cfg_data = 8'hC3; cfg_valid = 1'b1;
    snap();
    spi_frame(1, 16'h0012, 27, 1'b1, resp);
    repeat (20) @(negedge clk);
    chk("mode3_response", 32'(resp), 32'hC3);
    chk("mode3_rx_data", 32'(rx_last[1]), 32'h0012);
    chk("mode3_rd_req_count", 32'(rd_cnt[1] - s_rd[1]), 32'd1);
    chk("mode3_underrun_count", 32'(und_cnt[1] - s_und[1]), 32'd0);

    // Reset in the middle of the response, then a normal frame
    spi_frame(0, 16'h0012, 22, 1'b0, resp);
    chk("pre_reset_miso_oe", 32'(miso_oe0), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_tx_outputs", 32'({miso0, miso_oe0}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ss0_n   = 1'b1;
    repeat (20) @(negedge clk);
    spi_frame(0, 16'h0012, 27, 1'b1, resp);
    repeat (20) @(negedge clk);
    chk("post_reset_response", 32'(resp), 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
